// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage hazard detection and forwarding-select controller
//
// Tracks destination-register metadata for the instructions in EX, MEM, WB and
// one slot past WB (RET), and decides for each ID instruction whether it must
// stall (load-use) and which forwarding path each operand takes in EX.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_*                decoded fields of the instruction currently in ID
//   flush               branch taken in EX; the ID instruction is killed
//   mem_ready           0 freezes every piece of state in this block
//   stall_if_id         hold PC and IF/ID (combinational)
//   ex_bubble           EX holds a bubble inserted by load-use or flush
//   ex_valid            EX holds a real instruction
//   SelFwA / SelFwB     forward selects for EX: 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 RET
//   stall_count         saturating number of load-use stall cycles

module ex_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int XLEN_REGS = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [$clog2(XLEN_REGS)-1:0]  id_rs1,
  input  logic [$clog2(XLEN_REGS)-1:0]  id_rs2,
  input  logic                          id_use_rs1,
  input  logic                          id_use_rs2,
  input  logic [$clog2(XLEN_REGS)-1:0]  id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic                          flush,
  input  logic                          mem_ready,
  output logic                          stall_if_id,
  output logic                          ex_bubble,
  output logic                          ex_valid,
  output logic [1:0]                    SelFwA,
  output logic [1:0]                    SelFwB,
  output logic [CNT_W-1:0]              stall_count
);

  localparam int RW = $clog2(XLEN_REGS);

  // Shadow slots. ex_valid doubles as the EX slot valid bit. The RET slot is
  // reached through the Fw3 select, which is decided while the producer is
  // still in WB, so RET itself needs no stored metadata here.
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic          ex_rw, ex_mr;
  logic          mem_v, mem_rw;
  logic          wb_v, wb_rw;

  logic          load_use;
  logic          entry_v;
  logic [1:0]    sel_a_d, sel_b_d;

  function automatic logic match(input logic v, input logic rw,
                                 input logic [RW-1:0] rd, input logic [RW-1:0] rs);
    return v & rw & (rd == rs) & (rs != '0);
  endfunction

  // Youngest producer wins. A load in EX never forwards from Fw1; that case
  // is a load-use stall, and after the stall the load is seen in MEM (Fw2).
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [RW-1:0] rs);
    logic [1:0] s;
    s = 2'd0;
    if (use_rs) begin
      if (match(ex_valid, ex_rw, ex_rd, rs) && !ex_mr) s = 2'd1;
      else if (match(mem_v, mem_rw, mem_rd, rs))       s = 2'd2;
      else if (match(wb_v, wb_rw, wb_rd, rs))          s = 2'd3;
    end
    return s;
  endfunction

  always_comb begin
    load_use = id_valid & ex_valid & ex_mr & (ex_rd != '0) & ~flush &
               ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
    entry_v  = id_valid & ~flush & ~load_use;
    sel_a_d  = entry_v ? fwd_sel(id_use_rs1, id_rs1) : 2'd0;
    sel_b_d  = entry_v ? fwd_sel(id_use_rs2, id_rs2) : 2'd0;
  end

  assign stall_if_id = load_use | ~mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      mem_v       <= 1'b0;
      mem_rd      <= '0;
      mem_rw      <= 1'b0;
      wb_v        <= 1'b0;
      wb_rd       <= '0;
      wb_rw       <= 1'b0;
      ex_bubble   <= 1'b0;
      SelFwA      <= 2'd0;
      SelFwB      <= 2'd0;
      stall_count <= '0;
    end else if (mem_ready) begin
      wb_v      <= mem_v;
      wb_rd     <= mem_rd;
      wb_rw     <= mem_rw;
      mem_v     <= ex_valid;
      mem_rd    <= ex_rd;
      mem_rw    <= ex_rw;
      ex_valid  <= entry_v;
      ex_rd     <= id_rd;
      ex_rw     <= id_reg_write & entry_v;
      ex_mr     <= id_mem_read & entry_v;
      // Only bubbles that displaced a real ID instruction are flagged.
      ex_bubble <= id_valid & (flush | load_use);
      SelFwA    <= sel_a_d;
      SelFwB    <= sel_b_d;
      if (load_use && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Hazard and forwarding controller for the EX stage of the 5-stage RISC-V pipeline.
- Keeps a shadow pipeline of destination-register metadata for the EX, MEM, WB and RET (one cycle past WB) slots.
- Produces registered SelFwA/SelFwB for the forwarding muxes and detects load-use hazards, inserting a one-cycle bubble.
- Handles branch flush and the global memory-wait freeze.

Parameters:
- CNT_W, 16, width of the saturating load-use stall counter.
- XLEN_REGS, 32, number of architectural registers; register-index width is log2(XLEN_REGS).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  5  source register 1 of the ID instruction.
- id_rs2  input  5  source register 2 of the ID instruction.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  5  destination register of the ID instruction.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch taken in EX: kill the ID instruction.
- mem_ready  input  1  data memory ready; 0 freezes all state.
- stall_if_id  output  1  hold PC and IF/ID register (combinational).
- ex_bubble  output  1  EX slot holds an inserted bubble (registered).
- ex_valid  output  1  EX slot holds a real instruction (registered).
- SelFwA  output  2  forward select, operand A: 0 = regfile, 1 = Fw1 (EX/MEM), 2 = Fw2 (MEM/WB), 3 = Fw3 (RET) (registered).
- SelFwB  output  2  forward select, operand B, same encoding (registered).
- stall_count  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All slots invalid; SelFwA = SelFwB = 0.
  - ex_valid = 0, ex_bubble = 0, stall_count = 0.
  - stall_if_id follows its equation, so it is 0 while the slots are clear.
- Slot contents: each of EX, MEM, WB and RET holds {valid, rd, reg_write, mem_read}.
- Advance, on each edge with mem_ready=1: RET<=WB, WB<=MEM, MEM<=EX, EX<=entry.
  - Entry is the ID instruction when id_valid & ~flush & ~load_use.
  - Otherwise entry is a bubble (valid=0).
- Freeze: mem_ready=0 holds every slot, the select registers, ex_bubble, ex_valid and stall_count. flush is ignored while mem_ready=0; the branch unit holds flush until it is accepted.
- Match rule: match(slot, rs) = slot.valid & slot.reg_write & (slot.rd == rs) & (rs != 0). x0 never forwards and never stalls.
- Load-use hazard:
  - load_use = id_valid & EX.valid & EX.mem_read & EX.rd != 0 & ((id_use_rs1 & EX.rd == id_rs1) | (id_use_rs2 & EX.rd == id_rs2)).
  - load_use is forced to 0 when flush=1.
- stall_if_id = load_use | ~mem_ready.
- Forward-select computation, evaluated in the ID cycle against current slots and registered on the advance edge so the value is valid during the instruction's EX cycle:
  - match(EX) and EX is not a load -> 1.
  - else match(MEM) -> 2.
  - else match(WB) -> 3.
  - else 0.
  - Youngest producer wins.
  - Unused operand (id_use_rsX=0) -> 0.
  - Bubble entry -> 0.
- Load data always comes from Fw2. After the one-cycle stall the load sits in MEM, so the consumer selects 2.
- ex_bubble = 1 when the entry was a bubble caused by load_use or flush. A bubble from id_valid=0 gives ex_bubble = 0. ex_valid = entry.valid.
- stall_count increments on each advance edge where load_use=1 and saturates at all-ones.
- Simultaneous flush and load_use: flush wins, no stall, counter unchanged.
- Reset mid-freeze or mid-stall: all state clears immediately; no pending stall survives.
- Latency: SelFw valid in the cycle after the ID cycle. Load-use costs exactly one cycle per hazard.

Test Plan:
- Back-to-back ALU: add x5 (ID) then sub x6,x5,x7 -> consumer's EX cycle has SelFwA=1, SelFwB=0, no stall.
- Distance 2 and 3: producer x5, one unrelated instruction, consumer rs2=x5 -> SelFwB=2. With two unrelated instructions -> SelFwB=3. With three -> 0.
- Load-use: ld x8, then add x9,x8,x8 -> stall_if_id=1 for one cycle; next cycle ex_bubble=1; consumer EX has SelFwA=SelFwB=2; stall_count=1.
- x0 and priority: producers write x0 -> sel 0 and no stall on a load to x0. Two producers of x5 at distance 1 and 2 -> sel 1.
- Flush with load_use in the same cycle -> stall_if_id=0, ex_bubble=1 next cycle, stall_count unchanged. mem_ready=0 for 3 cycles -> all outputs held, stall_if_id=1 throughout.
- Reset: assert rst_n=0 during a stall cycle -> outputs zero immediately without a clock edge. stall_count driven to 0xFFFF stays at 0xFFFF on a further hazard.
